// File: rtl/pipe_ctrl_chain_pkg.sv
// pipe_pkg: shared definitions for the pipe_ctrl_chain register chain.
//   cap_edge_e  - capture-edge selector values (EDGE_POS / EDGE_NEG)
//   stage_sel_e - per-stage next-state select (load / hold / clear)
//   occ_w()     - width of the occupancy count for a given depth
package pipe_pkg;

  typedef enum logic {
    EDGE_POS = 1'b0,
    EDGE_NEG = 1'b1
  } cap_edge_e;

  typedef enum logic [1:0] {
    SEL_LOAD,
    SEL_HOLD,
    SEL_CLEAR
  } stage_sel_e;

  // Enough bits to count 0..depth valid stages.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_chain_stage.sv
// pipe_stage: one pipeline stage holding {valid, payload}.
//   clk, rst_n : capture clock, asynchronous active-low reset
//   i_sel      : SEL_LOAD takes i_valid/i_data, SEL_HOLD keeps state,
//                SEL_CLEAR loads an empty slot carrying RESET_VAL
//   i_data/i_valid : value offered by the previous stage
//   o_data/o_valid : registered stage contents
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter bit               NEG_EDGE  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_sel_e       i_sel,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH:0] r_q;
  logic [WIDTH:0] w_d;

  always_comb begin
    w_d = {1'b0, RESET_VAL};
    unique case (i_sel)
      SEL_LOAD:  w_d = {i_valid, i_data};
      SEL_HOLD:  w_d = r_q;
      default:   w_d = {1'b0, RESET_VAL};
    endcase
  end

  // Reset is asynchronous regardless of which clock edge captures.
  if (NEG_EDGE == EDGE_NEG) begin : g_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= {1'b0, RESET_VAL};
      else        r_q <= w_d;
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= {1'b0, RESET_VAL};
      else        r_q <= w_d;
    end
  end

  assign o_valid = r_q[WIDTH];
  assign o_data  = r_q[WIDTH-1:0];

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: DEPTH-stage register chain for a WIDTH-bit bundle with
// per-stage stall (hold) and flush (bubble insert), valid tracking and a
// saturating stall counter.
//   clk, rst_n        : capture clock (edge by NEG_EDGE), async active-low reset
//   in_data, in_valid : item offered to stage 0
//   in_ready          : stage 0 loads at the next capture edge
//   stall, flush      : stall[i]/flush[i] act on stage i and all younger stages
//   out_data          : stage taps, stage i at [i*WIDTH +: WIDTH]
//   out_valid         : per-stage valid
//   occupancy         : number of valid stages
//   stall_cnt         : capture edges on which stage 0 was held (saturating)
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 4,
  parameter bit               NEG_EDGE  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DEPTH-1:0]          stall,
  input  logic [DEPTH-1:0]          flush,
  output logic [DEPTH*WIDTH-1:0]    out_data,
  output logic [DEPTH-1:0]          out_valid,
  output logic [occ_w(DEPTH)-1:0]   occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int OCC_W = occ_w(DEPTH);

  logic [DEPTH-1:0] w_h;    // stage i is held by some stall at or above it
  logic [DEPTH-1:0] w_f;    // stage i is flushed by some flush at or above it
  logic [DEPTH-1:0] w_bub;  // the next-younger stage is held: take a bubble
  stage_sel_e       w_sel [DEPTH];
  logic             w_cnt_inc;
  logic [CNT_W-1:0] r_stall_cnt;

  // Prefix-OR from the oldest stage down towards stage 0.
  always_comb begin
    w_h[DEPTH-1] = stall[DEPTH-1];
    w_f[DEPTH-1] = flush[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_h[i] = stall[i] | w_h[i+1];
      w_f[i] = flush[i] | w_f[i+1];
    end
  end

  if (DEPTH > 1) begin : g_bub
    assign w_bub = {w_h[DEPTH-2:0], 1'b0};
  end else begin : g_nobub
    assign w_bub = '0;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_sd;
    logic             w_sv;

    // Flush beats stall; a held younger neighbour leaves a bubble behind.
    always_comb begin
      w_sel[g] = SEL_LOAD;
      if (w_f[g])        w_sel[g] = SEL_CLEAR;
      else if (w_h[g])   w_sel[g] = SEL_HOLD;
      else if (w_bub[g]) w_sel[g] = SEL_CLEAR;
    end

    if (g == 0) begin : g_src_in
      // Invalid input still lands as RESET_VAL so empty taps stay clean.
      assign w_sd = in_valid ? in_data : RESET_VAL;
      assign w_sv = in_valid;
    end else begin : g_src_prev
      assign w_sd = out_data[(g-1)*WIDTH +: WIDTH];
      assign w_sv = out_valid[g-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .NEG_EDGE  (NEG_EDGE),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_sel   (w_sel[g]),
      .i_data  (w_sd),
      .i_valid (w_sv),
      .o_data  (out_data[g*WIDTH +: WIDTH]),
      .o_valid (out_valid[g])
    );
  end

  assign in_ready = ~w_h[0] & ~w_f[0];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(out_valid[i]);
  end

  assign w_cnt_inc = w_h[0] & ~w_f[0] & ~(&r_stall_cnt);

  if (NEG_EDGE == EDGE_NEG) begin : g_cnt_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)         r_stall_cnt <= '0;
      else if (w_cnt_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end else begin : g_cnt_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_stall_cnt <= '0;
      else if (w_cnt_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: u_dut (WIDTH=8, DEPTH=4, falling-edge capture,
// CNT_W=4) is checked every cycle against an index-based model; u_pos
// (rising-edge capture, RESET_VAL=0x3C) covers edge selection and reset value.
module tb_pipe_ctrl_chain;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  stall, flush;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [2:0]  occupancy;
  logic [3:0]  stall_cnt;

  logic [7:0]  in2_data;
  logic        in2_valid;
  logic        in2_ready;
  logic [3:0]  stall2, flush2;
  logic [31:0] out2_data;
  logic [3:0]  out2_valid;
  logic [2:0]  occ2;
  logic [15:0] cnt2;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  pipe_ctrl_chain #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b1), .RESET_VAL(8'h00), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_ctrl_chain #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b0), .RESET_VAL(8'h3C), .CNT_W(16)) u_pos (
    .clk(clk), .rst_n(rst_n), .in_data(in2_data), .in_valid(in2_valid), .in_ready(in2_ready),
    .stall(stall2), .flush(flush2), .out_data(out2_data), .out_valid(out2_valid),
    .occupancy(occ2), .stall_cnt(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: find the oldest stalled and oldest flushed stage, then
  // everything at or below the flush index empties, everything else at or
  // below the stall index freezes, the slot just above the stall is a
  // bubble, and the rest shifts one place older.
  logic [7:0] m_data [4];
  bit         m_val  [4];
  int         m_cnt;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_data[i] = 8'h00; m_val[i] = 0; end
      m_cnt = 0;
    end else begin
      int ks, kf;
      logic [7:0] nd [4];
      bit nv [4];
      ks = -1; kf = -1;
      for (int j = 0; j < 4; j++) begin
        if (stall[j]) ks = j;
        if (flush[j]) kf = j;
      end
      for (int i = 0; i < 4; i++) begin
        if (i <= kf)                   begin nv[i] = 0; nd[i] = 8'h00; end
        else if (i <= ks)              begin nv[i] = m_val[i]; nd[i] = m_data[i]; end
        else if (ks >= 0 && i == ks+1) begin nv[i] = 0; nd[i] = 8'h00; end
        else if (i == 0)               begin nv[i] = in_valid; nd[i] = in_valid ? in_data : 8'h00; end
        else                           begin nv[i] = m_val[i-1]; nd[i] = m_data[i-1]; end
      end
      for (int i = 0; i < 4; i++) begin m_val[i] = nv[i]; m_data[i] = nd[i]; end
      if (ks >= 0 && kf < 0 && m_cnt < 15) m_cnt++;
    end
  end

  // Compare on the rising edge, half a period away from u_dut's capture edge.
  always @(posedge clk) begin
    if (chk_en) begin
      logic [31:0] ed;
      logic [3:0]  ev;
      int occ;
      occ = 0;
      for (int i = 0; i < 4; i++) begin
        ed[i*8 +: 8] = m_data[i];
        ev[i] = m_val[i];
        occ += int'(m_val[i]);
      end
      chk("model out_valid", out_valid, ev);
      chk("model out_data", out_data, ed);
      chk("model occupancy", occupancy, occ);
      chk("model stall_cnt", stall_cnt, m_cnt);
      chk("model in_ready", in_ready, (stall == 4'h0 && flush == 4'h0));
    end
  end

  task automatic drive(input logic [7:0] d, input logic v, input logic [3:0] s, input logic [3:0] f);
    in_data = d; in_valid = v; stall = s; flush = f;
  endtask

  task automatic edge1();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 4'h0, 4'h0);
    in2_data = 8'h00; in2_valid = 1'b0; stall2 = 4'h0; flush2 = 4'h0;
    #12;
    chk("reset out_valid", out_valid, 4'h0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset stall_cnt", stall_cnt, 4'h0);
    chk("reset occupancy", occupancy, 3'd0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset pos taps", out2_data, 32'h3C3C_3C3C);
    chk("reset pos valid", out2_valid, 4'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Free flow
    drive(8'h11, 1'b1, 4'h0, 4'h0); edge1(); chk("flow occ1", occupancy, 3'd1);
    drive(8'h22, 1'b1, 4'h0, 4'h0); edge1(); chk("flow occ2", occupancy, 3'd2);
    drive(8'h33, 1'b1, 4'h0, 4'h0); edge1(); chk("flow occ3", occupancy, 3'd3);
    drive(8'h44, 1'b1, 4'h0, 4'h0); edge1(); chk("flow occ4", occupancy, 3'd4);
    chk("flow tap3 first", out_data[31:24], 8'h11);
    drive(8'h55, 1'b1, 4'h0, 4'h0); edge1();
    chk("flow tap3 second", out_data[31:24], 8'h22);
    chk("flow occ stays", occupancy, 3'd4);

    // Stall stage 2 for two edges with the chain full
    drive(8'h66, 1'b1, 4'b0100, 4'h0); edge1(); edge1();
    chk("stall taps", out_data, 32'h0033_4455);
    chk("stall valid", out_valid, 4'b0111);
    chk("stall in_ready", in_ready, 1'b0);
    chk("stall cnt", stall_cnt, 4'd2);

    // Flush 1 together with stall 2
    drive(8'h77, 1'b1, 4'b0100, 4'b0010); edge1();
    chk("flush taps", out_data, 32'h0033_0000);
    chk("flush valid", out_valid, 4'b0100);
    chk("flush occ", occupancy, 3'd1);
    chk("flush cnt", stall_cnt, 4'd2);

    // Falling-edge capture: nothing on the rising edge
    drive(8'hA5, 1'b1, 4'h0, 4'h0);
    @(posedge clk); #1;
    chk("neg no capture on rise", out_data[7:0], 8'h00);
    @(negedge clk); #1;
    chk("neg capture on fall", out_data[7:0], 8'hA5);

    // Random traffic
    repeat (300) begin
      logic [3:0] s, f;
      for (int j = 0; j < 4; j++) begin
        s[j] = ($urandom_range(0, 7) == 0);
        f[j] = ($urandom_range(0, 9) == 0);
      end
      drive(8'($urandom), ($urandom_range(0, 3) != 0), s, f);
      edge1();
    end

    // Fill, then reset between edges while stalled
    repeat (4) begin drive(8'($urandom), 1'b1, 4'h0, 4'h0); edge1(); end
    drive(8'h99, 1'b1, 4'b0100, 4'h0); edge1();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid, 4'h0);
    chk("async rst taps", out_data, 32'h0);
    chk("async rst cnt", stall_cnt, 4'd0);
    chk("async rst occ", occupancy, 3'd0);
    #3 rst_n = 1'b1;

    // Saturation of the 4-bit counter
    drive(8'h00, 1'b0, 4'b0001, 4'h0);
    repeat (14) edge1();
    chk("sat cnt 14", stall_cnt, 4'd14);
    repeat (6) edge1();
    chk("sat cnt 15", stall_cnt, 4'd15);

    // Rising-edge instance: capture on rise only, invalid loads RESET_VAL
    in2_data = 8'hA5; in2_valid = 1'b1;
    #1;
    chk("pos before rise", out2_data[7:0], 8'h3C);
    @(posedge clk); #1;
    chk("pos capture tap0", out2_data[7:0], 8'hA5);
    chk("pos capture valid", out2_valid, 4'b0001);
    in2_data = 8'hFF; in2_valid = 1'b0;
    @(negedge clk); #1;
    chk("pos no capture on fall", out2_data[7:0], 8'hA5);
    @(posedge clk); #1;
    chk("pos invalid tap0", out2_data[15:0], 16'hA53C);
    chk("pos shift valid", out2_valid, 4'b0010);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
